// File: rtl/flappybird_keycode_pkg.sv
// Shared definitions for the keycode FIFO Avalon-MM slave.
// Holds the register map, STATUS/CONTROL bit positions and a helper that packs
// the STATUS word.
package flappybird_keycode_pkg;

  // Avalon-MM word addresses
  typedef enum logic [1:0] {
    RegData    = 2'd0,
    RegStatus  = 2'd1,
    RegControl = 2'd2,
    RegLast    = 2'd3
  } reg_addr_e;

  // STATUS bit positions
  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusCountLsb = 8;
  localparam int unsigned StatusCountW   = 8;

  // CONTROL bit positions
  localparam int unsigned ControlIrqEnBit = 0;
  localparam int unsigned ControlFlushBit = 1;

  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[StatusEmptyBit] = empty;
    w[StatusFullBit]  = full;
    w[StatusOvfBit]   = overflow;
    w[StatusCountLsb +: StatusCountW] = count;
    return w;
  endfunction

endpackage

// File: rtl/flappybird_sync_fifo.sv
// Single-clock FIFO storing keycodes.
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : enqueue request and data (dropped when full unless popping)
//   pop             : dequeue request (ignored when empty)
//   flush           : empties the FIFO; overrides same-cycle push/pop
//   head_data       : entry at the read pointer (undefined when empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries
module flappybird_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;
  localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);
  localparam logic [CountW-1:0] CountOne  = CountW'(1);
  localparam logic [AddrW-1:0]  PtrOne    = AddrW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CountFull);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/flappybird_keycode_fifo.sv
// Avalon-MM keycode FIFO with streaming consumer port and level interrupt.
//   clk, reset            : clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side (DATA/STATUS/CONTROL/LAST)
//   readdata              : combinational register read data
//   out_port, out_valid   : FIFO head (0 when empty) and non-empty flag
//   out_ready             : consumer pop request
//   irq                   : registered irq_en & overflow
module flappybird_keycode_fifo
  import flappybird_keycode_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic              data_wr, status_wr, control_wr;
  logic              flush, pop, overflow_set;
  logic              fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_head;

  logic              overflow_q, overflow_d;
  logic              irq_en_q, irq_en_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              irq_q, irq_d;

  logic              unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    data_wr    = 1'b0;
    status_wr  = 1'b0;
    control_wr = 1'b0;
    if (wr_en) begin
      unique case (reg_addr_e'(address))
        RegData:    data_wr    = 1'b1;
        RegStatus:  status_wr  = 1'b1;
        RegControl: control_wr = 1'b1;
        RegLast:    ;
      endcase
    end
  end

  assign flush        = control_wr & writedata[ControlFlushBit];
  assign out_valid    = ~fifo_empty;
  assign pop          = out_valid & out_ready;
  assign overflow_set = data_wr & fifo_full & ~pop & ~flush;
  assign out_port     = fifo_empty ? '0 : fifo_head;
  assign irq          = irq_q;

  flappybird_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (writedata[DATA_W-1:0]),
    .pop       (pop),
    .flush     (flush),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (status_wr && writedata[StatusOvfBit]) overflow_d = 1'b0;
    if (overflow_set)                         overflow_d = 1'b1;
    irq_en_d = control_wr ? writedata[ControlIrqEnBit] : irq_en_q;
    // A flush discards the head, so it is never recorded as popped.
    last_d   = (pop && !flush) ? fifo_head : last_q;
    irq_d    = irq_en_q & overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      last_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      last_q     <= last_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (reg_addr_e'(address))
      RegData:    readdata = 32'(out_port);
      RegStatus:  readdata = status_word(fifo_empty, fifo_full, overflow_q,
                                         StatusCountW'(fifo_count));
      RegControl: readdata[ControlIrqEnBit] = irq_en_q;
      RegLast:    readdata = 32'(last_q);
    endcase
  end

endmodule
